muldiv_sequencer: RTL and testbench

//  Multi-cycle MULT/MULTU/DIV/DIVU engine and HI/LO write-port controller.

---
 rtl/muldiv_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle MULT/MULTU/DIV/DIVU engine and HI/LO write-port controller.
//   Latches operands on start, runs shift-add multiply or restoring divide on
//   operand magnitudes, applies sign correction, then pulses a 64-bit HI/LO
//   write. Requests a pipeline stall while computing; an exception flush
//   (cancel) aborts the operation without writing.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   start      request, sampled only in IDLE
//   op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a      rs value (multiplicand / dividend)
//   src_b      rt value (multiplier / divisor)
//   cancel     exception flush, aborts the operation in progress
//   busy       state != IDLE
//   stall_req  high in CALC and FIX
//   done       one-cycle pulse in DONE
//   hilo_we    HI/LO write enable (equals done)
//   hilo_data  {HI, LO}, held until the next DONE
//
// Configuration
//   MULDIV_FAST_MULT_EN : MULT/MULTU skip CALC and use one combinational
//                         multiply in FIX. Divide is unaffected.
module muldiv_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_W-1:0]     src_a,
    input  logic [DATA_W-1:0]     src_b,
    input  logic                  cancel,
    output logic                  busy,
    output logic                  stall_req,
    output logic                  done,
    output logic                  hilo_we,
    output logic [2*DATA_W-1:0]   hilo_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t                state_q, state_d;
    logic                  is_div_q;
    logic                  sign_a_q, sign_b_q;
    logic [DATA_W-1:0]     mag_a_q, mag_b_q, raw_a_q;
    logic [2*DATA_W-1:0]   acc_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  accept;
    logic                  in_sign_a, in_sign_b;
    logic [DATA_W-1:0]     in_mag_a, in_mag_b;
    logic [DATA_W:0]       mul_sum;
    logic [2*DATA_W-1:0]   mul_next;
    logic [DATA_W:0]       div_sh;
    logic                  div_ge;
    logic [2*DATA_W-1:0]   div_next;
    logic [2*DATA_W-1:0]   prod_raw;
    logic [DATA_W-1:0]     quo, rem;
    logic                  neg_res;
    logic [2*DATA_W-1:0]   fix_result;

    assign accept = (state_q == S_IDLE) && start && !cancel;

    // Signed ops (op[0]==0) work on magnitudes; unsigned ops keep sign bits
    // clear so the correction step becomes a no-op.
    always_comb begin
        in_sign_a = !op[0] && src_a[DATA_W-1];
        in_sign_b = !op[0] && src_b[DATA_W-1];
        in_mag_a  = in_sign_a ? -src_a : src_a;
        in_mag_b  = in_sign_b ? -src_b : src_b;
    end

    // One iteration of each algorithm. Both share acc_q:
    //   multiply: {partial product high, remaining multiplier bits}
    //   divide  : {partial remainder, remaining dividend / quotient bits}
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
        mul_next = {mul_sum, acc_q[DATA_W-1:1]};

        div_sh   = acc_q[2*DATA_W-1:DATA_W-1];
        div_ge   = div_sh >= {1'b0, mag_b_q};
        // The difference always fits in DATA_W bits because the remainder
        // stays below the divisor.
        div_next = {(div_ge ? div_sh[DATA_W-1:0] - mag_b_q : div_sh[DATA_W-1:0]),
                    acc_q[DATA_W-2:0], div_ge};
    end

    always_comb begin
`ifdef MULDIV_FAST_MULT_EN
        prod_raw = {{DATA_W{1'b0}}, mag_a_q} * {{DATA_W{1'b0}}, mag_b_q};
`else
        prod_raw = acc_q;
`endif
        quo     = acc_q[DATA_W-1:0];
        rem     = acc_q[2*DATA_W-1:DATA_W];
        neg_res = sign_a_q ^ sign_b_q;
        if (!is_div_q)
            fix_result = neg_res ? -prod_raw : prod_raw;
        else if (mag_b_q == '0)
            fix_result = {raw_a_q, {DATA_W{1'b1}}};
        else
            fix_result = {(sign_a_q ? -rem : rem), (neg_res ? -quo : quo)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        stall_req = 1'b0;
        done      = 1'b0;
        hilo_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef MULDIV_FAST_MULT_EN
                    state_d = op[1] ? S_CALC : S_FIX;
`else
                    state_d = S_CALC;
`endif
                end
            end
            S_CALC: begin
                busy      = 1'b1;
                stall_req = 1'b1;
                if (cancel)
                    state_d = S_IDLE;
                else if (cnt_q == CNT_LAST)
                    state_d = S_FIX;
            end
            S_FIX: begin
                busy      = 1'b1;
                stall_req = 1'b1;
                state_d   = cancel ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                hilo_we = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_div_q  <= 1'b0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            raw_a_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            hilo_data <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        is_div_q <= op[1];
                        sign_a_q <= in_sign_a;
                        sign_b_q <= in_sign_b;
                        mag_a_q  <= in_mag_a;
                        mag_b_q  <= in_mag_b;
                        raw_a_q  <= src_a;
                        cnt_q    <= '0;
                        acc_q    <= op[1] ? {{DATA_W{1'b0}}, in_mag_a}
                                          : {{DATA_W{1'b0}}, in_mag_b};
                    end
                end
                S_CALC: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                S_FIX: begin
                    if (!cancel)
                        hilo_data <= fix_result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    localparam int DW = 32;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [DW-1:0] src_a = '0;
    logic [DW-1:0] src_b = '0;
    logic          cancel = 1'b0;
    logic          busy, stall_req, done, hilo_we;
    logic [2*DW-1:0] hilo_data;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_sequencer #(.DATA_W(DW), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .cancel    (cancel),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .hilo_we   (hilo_we),
        .hilo_data (hilo_data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start one op, optionally holding start high with junk operands while busy,
    // then check latency, stall window, result and the single-cycle pulse.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [63:0] exp, input int exp_lat,
                          input bit hold_start);
        int n;
        int stall_cnt;
        bit seen;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = hold_start;
        n = 1; stall_cnt = 0; seen = 1'b0;
        while (n <= 200) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (stall_req) stall_cnt++;
            src_a = $urandom; src_b = $urandom; op = 2'($urandom_range(0, 3));
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check_eq({tag, " latency"}, seen ? 64'(n) : 64'd0, 64'(exp_lat));
        check_eq({tag, " data"}, hilo_data, exp);
        check_eq({tag, " we"}, 64'(hilo_we), 64'd1);
        check_eq({tag, " stall_at_done"}, 64'(stall_req), 64'd0);
        check_eq({tag, " stall_cycles"}, 64'(stall_cnt), 64'(exp_lat - 1));
        @(negedge clk);
        check_eq({tag, " done_pulse"}, 64'(done), 64'd0);
        check_eq({tag, " idle_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        bit we_seen;
        repeat (2) @(negedge clk);
        check_eq("rst busy", 64'(busy), 64'd0);
        check_eq("rst stall", 64'(stall_req), 64'd0);
        check_eq("rst done", 64'(done), 64'd0);
        check_eq("rst we", 64'(hilo_we), 64'd0);
        check_eq("rst data", hilo_data, 64'd0);
        rst = 1'b1;

        run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, DIV_LAT, 1'b0);
        run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, DIV_LAT, 1'b0);
        run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, DIV_LAT, 1'b0);
        run_op("div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, DIV_LAT, 1'b0);
        run_op("mult_m1_2", 2'b00, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFE, MUL_LAT, 1'b0);
        run_op("multu_ff_2", 2'b01, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, MUL_LAT, 1'b0);
        run_op("mult_min_min", 2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, MUL_LAT, 1'b0);
        run_op("multu_ff_ff", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, MUL_LAT, 1'b0);
        run_op("divu_by0", 2'b11, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF, DIV_LAT, 1'b0);
        run_op("div_by0", 2'b10, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF, DIV_LAT, 1'b0);
        run_op("div_neg_by0", 2'b10, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, DIV_LAT, 1'b0);

        // cancel together with start in IDLE: stays idle
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 2'b11; src_a = 32'd9; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        check_eq("cancel_start busy", 64'(busy), 64'd0);

        // cancel in cycle 10 of a DIVU
        @(negedge clk);
        start = 1'b1; op = 2'b11; src_a = 32'd500; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        we_seen = 1'b0;
        for (int c = 1; c < 10; c++) begin
            we_seen |= hilo_we;
            @(negedge clk);
        end
        cancel = 1'b1;
        we_seen |= hilo_we;
        @(negedge clk);
        cancel = 1'b0;
        we_seen |= hilo_we;
        check_eq("cancel busy", 64'(busy), 64'd0);
        check_eq("cancel no_we", 64'(we_seen), 64'd0);
        check_eq("cancel data_kept", hilo_data, 64'hFFFFFFF9_FFFFFFFF);
        run_op("after_cancel", 2'b11, 32'd1000, 32'd10, 64'h00000000_00000064, DIV_LAT, 1'b0);

        // reset mid-MULTU in cycle 15
        @(negedge clk);
        start = 1'b1; op = 2'b01; src_a = 32'd5; src_b = 32'd6;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 15; c++) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("midrst busy", 64'(busy), 64'd0);
        check_eq("midrst stall", 64'(stall_req), 64'd0);
        check_eq("midrst done", 64'(done), 64'd0);
        check_eq("midrst we", 64'(hilo_we), 64'd0);
        check_eq("midrst data", hilo_data, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // start held high with changing operands while busy
        run_op("multu_hold", 2'b01, 32'h00010000, 32'h00010000, 64'h00000001_00000000, MUL_LAT, 1'b1);
        run_op("div_hold", 2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, DIV_LAT, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
